// File: rtl/axo32_encoder.sv
// -----------------------------------------------------------------------------
// axo32_encoder
//   Streaming RV32I instruction encoder (inverse of axo32_decoder). Takes
//   field-level requests on a valid/ready handshake and produces 32-bit
//   instruction words on a registered valid/ready output. The pseudo-op LI is
//   expanded into LUI and/or ADDI.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   request accepted when req_valid && req_ready
//   req_op     in   5   opcode field inst[6:2]
//   req_li     in   1   pseudo LI rd,imm (req_op ignored)
//   req_funct3 in   3   funct3
//   req_alt    in   1   inst[30] (SUB/SRA/SRAI)
//   req_rd     in   5   rd
//   req_rs1    in   5   rs1
//   req_rs2    in   5   rs2
//   req_imm    in   32  full immediate (byte offset for B/J, value<<12 for U)
//   out_valid  out  1   out_inst valid
//   out_ready  in   1   consumer takes word when out_valid && out_ready
//   out_inst   out  32  encoded instruction
//   err        out  1   one-cycle pulse: request rejected
//
// Configuration
//   AXO_ENC_CHECK_EN : when defined, immediates are range-checked before
//                      encoding and an out-of-range request is rejected with
//                      err. When undefined, excess immediate bits are dropped.
// -----------------------------------------------------------------------------
module axo32_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic        req_li,
    input  logic [2:0]  req_funct3,
    input  logic        req_alt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        err
);

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    typedef enum logic {
        S_IDLE,
        S_SECOND
    } state_t;

    state_t      state_reg, state_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_inst_reg, out_inst_next;
    logic        err_reg, err_next;
    logic [31:0] pend_reg, pend_next;

    // ------------------------------------------------------------------
    // Format assembly
    // ------------------------------------------------------------------
    logic        is_shift;
    logic [31:0] i_word, sh_word, s_word, r_word, b_word, u_word, j_word;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        range_bad;

    assign is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);

    assign i_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_op, 2'b11};
    assign sh_word = {1'b0, req_alt, 5'b00000, req_imm[4:0], req_rs1, req_funct3,
                      req_rd, req_op, 2'b11};
    assign s_word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0],
                      req_op, 2'b11};
    assign r_word  = {1'b0, req_alt, 5'b00000, req_rs2, req_rs1, req_funct3,
                      req_rd, req_op, 2'b11};
    assign b_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                      req_imm[4:1], req_imm[11], req_op, 2'b11};
    assign u_word  = {req_imm[31:12], req_rd, req_op, 2'b11};
    assign j_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                      req_rd, req_op, 2'b11};

    always_comb begin
        enc_word = 32'd0;
        enc_ok   = 1'b1;
        case (req_op)
            OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM: enc_word = i_word;
            OP_OP_IMM:           enc_word = is_shift ? sh_word : i_word;
            OP_STORE:            enc_word = s_word;
            OP_OP:               enc_word = r_word;
            OP_BRANCH:           enc_word = b_word;
            OP_LUI, OP_AUIPC:    enc_word = u_word;
            OP_JAL:              enc_word = j_word;
            default:             enc_ok   = 1'b0;
        endcase
    end

`ifdef AXO_ENC_CHECK_EN
    // Signed range tests reduce to "all bits above the top kept bit equal
    // the sign bit".
    logic i_fits, b_fits, j_fits;

    assign i_fits = (&req_imm[31:11]) || (~|req_imm[31:11]);
    assign b_fits = (&req_imm[31:12]) || (~|req_imm[31:12]);
    assign j_fits = (&req_imm[31:20]) || (~|req_imm[31:20]);

    always_comb begin
        range_bad = 1'b0;
        case (req_op)
            OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM, OP_STORE:
                range_bad = !i_fits;
            OP_OP_IMM:
                range_bad = is_shift ? (|req_imm[31:5]) : !i_fits;
            OP_BRANCH:
                range_bad = req_imm[0] || !b_fits;
            OP_JAL:
                range_bad = req_imm[0] || !j_fits;
            OP_LUI, OP_AUIPC:
                range_bad = |req_imm[11:0];
            default:
                range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // LI expansion. Adding 0x800 before taking the upper part compensates
    // for ADDI sign-extending the low 12 bits.
    // ------------------------------------------------------------------
    logic [31:0] li_sum;
    logic [19:0] li_hi;
    logic        li_hi_nz, li_lo_nz;
    logic [31:0] li_lui_word, li_addi0_word, li_addi_rd_word;

    assign li_sum          = req_imm + 32'h0000_0800;
    assign li_hi           = li_sum[31:12];
    assign li_hi_nz        = |li_hi;
    assign li_lo_nz        = |req_imm[11:0];
    assign li_lui_word     = {li_hi, req_rd, OP_LUI, 2'b11};
    assign li_addi0_word   = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_OP_IMM, 2'b11};
    assign li_addi_rd_word = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_OP_IMM, 2'b11};

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic take;

    assign take      = out_valid_reg && out_ready;
    assign req_ready = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_inst_next  = out_inst_reg;
        err_next       = 1'b0;
        pend_next      = pend_reg;

        if (take) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_li) begin
                        out_valid_next = 1'b1;
                        if (!li_hi_nz) begin
                            out_inst_next = li_addi0_word;
                        end else begin
                            out_inst_next = li_lui_word;
                            if (li_lo_nz) begin
                                pend_next  = li_addi_rd_word;
                                state_next = S_SECOND;
                            end
                        end
                    end else if (enc_ok && !range_bad) begin
                        out_valid_next = 1'b1;
                        out_inst_next  = enc_word;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_SECOND: begin
                // LUI is on the output; the ADDI follows the moment it leaves.
                if (take) begin
                    out_valid_next = 1'b1;
                    out_inst_next  = pend_reg;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            out_inst_reg  <= 32'd0;
            err_reg       <= 1'b0;
            pend_reg      <= 32'd0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_inst_reg  <= out_inst_next;
            err_reg       <= err_next;
            pend_reg      <= pend_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_inst  = out_inst_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_axo32_encoder.sv
// -----------------------------------------------------------------------------
// tb_axo32_encoder
//   Self-checking bench for axo32_encoder: reset state, a table of known
//   encodings, hand-written LI/back-pressure/reset sequences, and randomized
//   requests scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axo32_encoder;

    localparam logic [4:0] T_LOAD     = 5'b00000;
    localparam logic [4:0] T_MISC_MEM = 5'b00011;
    localparam logic [4:0] T_OP_IMM   = 5'b00100;
    localparam logic [4:0] T_AUIPC    = 5'b00101;
    localparam logic [4:0] T_OP_IMM32 = 5'b00110;
    localparam logic [4:0] T_STORE    = 5'b01000;
    localparam logic [4:0] T_OP       = 5'b01100;
    localparam logic [4:0] T_LUI      = 5'b01101;
    localparam logic [4:0] T_OP_32    = 5'b01110;
    localparam logic [4:0] T_BRANCH   = 5'b11000;
    localparam logic [4:0] T_JALR     = 5'b11001;
    localparam logic [4:0] T_JAL      = 5'b11011;
    localparam logic [4:0] T_SYSTEM   = 5'b11100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic        req_li = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic        req_alt = 1'b0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        err;

    always #5 clk = ~clk;

    axo32_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_li    (req_li),
        .req_funct3(req_funct3),
        .req_alt   (req_alt),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .err       (err)
    );

    typedef struct {
        logic [4:0]  op;
        logic        li;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          e;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    bit          err_due = 1'b0;
    bit          hold_chk = 1'b0;
    logic [31:0] hold_word = '0;
    bit          accepted = 1'b0;
    bit          rand_ready = 1'b0;
    vec_t        cur;

    // ------------------------------------------------------------------
    // Reference model: field placement written as shifts and masks on the
    // numeric immediate; LI split derived as lo = signed low 12 bits,
    // hi = (imm - lo) / 4096.
    // ------------------------------------------------------------------
    function automatic logic [31:0] tail(input logic [4:0] rd, input logic [4:0] op);
        return (32'(rd) << 7) | (32'(op) << 2) | 32'd3;
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] op);
        return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | tail(rd, op);
    endfunction

    function automatic void model(input vec_t r, output int n, output logic [31:0] w0,
                                  output logic [31:0] w1, output bit e);
        int          s;
        int          lo;
        logic [31:0] d;
        logic [31:0] rest;
        bit          shift;
        n = 0; w0 = '0; w1 = '0; e = 1'b0;
        s = int'(r.imm);
        rest = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12);
        shift = (r.op == T_OP_IMM) && (r.f3 == 3'd1 || r.f3 == 3'd5);
        if (r.li) begin
            lo = (int'(r.imm & 32'hFFF) ^ 32'h800) - 32'h800;
            d  = r.imm - 32'(lo);
            if ((d >> 12) == 32'd0) begin
                n = 1; w0 = enc_i(32'(lo), 5'd0, 3'd0, r.rd, T_OP_IMM);
            end else if (lo == 0) begin
                n = 1; w0 = d | tail(r.rd, T_LUI);
            end else begin
                n = 2; w0 = d | tail(r.rd, T_LUI);
                w1 = enc_i(32'(lo), r.rd, 3'd0, r.rd, T_OP_IMM);
            end
            return;
        end
        case (r.op)
            T_LOAD, T_MISC_MEM, T_JALR, T_SYSTEM, T_OP_IMM: begin
                if (shift)
                    w0 = (32'(r.alt) << 30) | ((r.imm & 32'h1F) << 20) | (32'(r.rs1) << 15)
                         | (32'(r.f3) << 12) | tail(r.rd, r.op);
                else
                    w0 = enc_i(r.imm, r.rs1, r.f3, r.rd, r.op);
`ifdef AXO_ENC_CHECK_EN
                if (shift) e = (r.imm >> 5) != 32'd0;
                else       e = (s < -2048) || (s > 2047);
`endif
            end
            T_STORE: begin
                w0 = (((r.imm >> 5) & 32'h7F) << 25) | rest | ((r.imm & 32'h1F) << 7)
                     | (32'(r.op) << 2) | 32'd3;
`ifdef AXO_ENC_CHECK_EN
                e = (s < -2048) || (s > 2047);
`endif
            end
            T_OP: w0 = (32'(r.alt) << 30) | rest | tail(r.rd, r.op);
            T_BRANCH: begin
                w0 = (((r.imm >> 12) & 32'h1) << 31) | (((r.imm >> 5) & 32'h3F) << 25) | rest
                     | (((r.imm >> 1) & 32'hF) << 8) | (((r.imm >> 11) & 32'h1) << 7)
                     | (32'(r.op) << 2) | 32'd3;
`ifdef AXO_ENC_CHECK_EN
                e = (s % 2 != 0) || (s < -4096) || (s > 4094);
`endif
            end
            T_LUI, T_AUIPC: begin
                w0 = (r.imm & 32'hFFFFF000) | tail(r.rd, r.op);
`ifdef AXO_ENC_CHECK_EN
                e = (r.imm & 32'hFFF) != 32'd0;
`endif
            end
            T_JAL: begin
                w0 = (((r.imm >> 20) & 32'h1) << 31) | (((r.imm >> 1) & 32'h3FF) << 21)
                     | (((r.imm >> 11) & 32'h1) << 20) | (((r.imm >> 12) & 32'hFF) << 12)
                     | tail(r.rd, r.op);
`ifdef AXO_ENC_CHECK_EN
                e = (s % 2 != 0) || (s < -1048576) || (s > 1048574);
`endif
            end
            default: e = 1'b1;
        endcase
        if (!e) n = 1;
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic li, input logic [2:0] f3,
                                input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm, input int n,
                                input logic [31:0] w0, input logic [31:0] w1, input bit e);
        vec_t v;
        v.op = op; v.li = li; v.f3 = f3; v.alt = alt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.n = n; v.w0 = w0; v.w1 = w1; v.e = e;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // One clock of observation: check err timing, hold stability, taken
    // words against the expected queue, and note acceptance.
    // ------------------------------------------------------------------
    task automatic tick();
        logic [31:0] w;
        @(negedge clk);
        total++;
        if (err !== err_due) begin
            bad++;
            $display("FAIL err_pulse: got %b want %b", err, err_due);
        end
        err_due = 1'b0;
        if (hold_chk) begin
            total++;
            if (out_valid !== 1'b1 || out_inst !== hold_word) begin
                bad++;
                $display("FAIL hold: got valid=%b inst=%h want valid=1 inst=%h",
                         out_valid, out_inst, hold_word);
            end
        end
        hold_chk  = (out_valid === 1'b1) && !out_ready;
        hold_word = out_inst;
        if (out_valid === 1'b1 && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got %h want none", out_inst);
            end else begin
                w = exp_q.pop_front();
                if (out_inst !== w) begin
                    bad++;
                    $display("FAIL word: got %h want %h", out_inst, w);
                end else begin
                    $display("word %h ok", out_inst);
                end
            end
        end
        if (req_valid && req_ready === 1'b1) begin
            accepted = 1'b1;
            if (cur.n > 0) exp_q.push_back(cur.w0);
            if (cur.n > 1) exp_q.push_back(cur.w1);
            err_due = cur.e;
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input vec_t v, output int ticks);
        req_op = v.op; req_li = v.li; req_funct3 = v.f3; req_alt = v.alt;
        req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
        req_valid = 1'b1;
        cur = v;
        accepted = 1'b0;
        ticks = 0;
        while (!accepted && ticks < 40) begin
            tick();
            ticks++;
        end
        req_valid = 1'b0;
        $display("req op=%b li=%b f3=%0d imm=%h expect n=%0d err=%0b after %0d cycles",
                 v.op, v.li, v.f3, v.imm, v.n, v.e, ticks);
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept want accept within 40 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1 || err_due) && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || out_valid === 1'b1) begin
            bad++;
            $display("FAIL drain: got %0d words outstanding want 0", exp_q.size());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    vec_t tbl[$];
    vec_t v;
    int   t;
    int   n_m;
    logic [31:0] m0, m1;
    bit   e_m;
    logic [4:0] sup_ops[11];

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_inst", out_inst, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // ---------------- table of known encodings ----------------
        tbl.push_back(mk(T_OP_IMM, 0, 3'd0, 0, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF08293, 0, 0));
        tbl.push_back(mk(T_OP_IMM, 1, 3'd0, 0, 5'd10, 5'd0, 5'd0, 32'h12345678, 2, 32'h12345537, 32'h67850513, 0));
        tbl.push_back(mk(T_OP_IMM, 1, 3'd0, 0, 5'd10, 5'd0, 5'd0, 32'h00000800, 2, 32'h00001537, 32'h80050513, 0));
        tbl.push_back(mk(T_OP_IMM, 1, 3'd0, 0, 5'd10, 5'd0, 5'd0, 32'h00000005, 1, 32'h00500513, 0, 0));
        tbl.push_back(mk(T_OP_IMM, 1, 3'd0, 0, 5'd10, 5'd0, 5'd0, 32'h12345000, 1, 32'h12345537, 0, 0));
        tbl.push_back(mk(T_OP_IMM, 1, 3'd0, 0, 5'd10, 5'd0, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF00513, 0, 0));
        tbl.push_back(mk(T_BRANCH, 0, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'h00000008, 1, 32'h00208463, 0, 0));
        tbl.push_back(mk(T_BRANCH, 0, 3'd1, 0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFE, 1, 32'hFE209FE3, 0, 0));
        tbl.push_back(mk(T_OP, 0, 3'd0, 1, 5'd3, 5'd4, 5'd5, 32'h0, 1, 32'h405201B3, 0, 0));
        tbl.push_back(mk(T_OP_IMM, 0, 3'd5, 1, 5'd6, 5'd7, 5'd0, 32'h00000003, 1, 32'h4033D313, 0, 0));
        tbl.push_back(mk(T_STORE, 0, 3'd2, 0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1, 32'hFE20AE23, 0, 0));
        tbl.push_back(mk(T_JAL, 0, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1, 32'h001000EF, 0, 0));
        tbl.push_back(mk(T_LUI, 0, 3'd0, 0, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 1, 32'hABCDE3B7, 0, 0));
        tbl.push_back(mk(T_OP_32, 0, 3'd0, 0, 5'd1, 5'd2, 5'd3, 32'h0, 0, 0, 0, 1));
        tbl.push_back(mk(T_OP_IMM32, 0, 3'd0, 0, 5'd1, 5'd2, 5'd3, 32'h5, 0, 0, 0, 1));
        tbl.push_back(mk(5'b11111, 0, 3'd0, 0, 5'd1, 5'd2, 5'd3, 32'h5, 0, 0, 0, 1));
`ifdef AXO_ENC_CHECK_EN
        tbl.push_back(mk(T_BRANCH, 0, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'h00000007, 0, 0, 0, 1));
        tbl.push_back(mk(T_OP_IMM, 0, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h00001000, 0, 0, 0, 1));
`else
        tbl.push_back(mk(T_BRANCH, 0, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'h00000007, 1, 32'h00208363, 0, 0));
        tbl.push_back(mk(T_OP_IMM, 0, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h00001000, 1, 32'h00000093, 0, 0));
`endif
        out_ready = 1'b1;
        for (int i = 0; i < tbl.size(); i++) send(tbl[i], t);
        drain();

        // ---------------- back-to-back single words: one per cycle ----------------
        for (int i = 0; i < 4; i++) begin
            send(mk(T_OP_IMM, 0, 3'd0, 0, 5'(i + 1), 5'd1, 5'd0, 32'(i), 1,
                    enc_i(32'(i), 5'd1, 3'd0, 5'(i + 1), T_OP_IMM), 0, 0), t);
            chk("throughput_cycles", 32'(t), 32'd1);
        end
        drain();

        // ---------------- LI: req_ready low between the two words ----------------
        send(tbl[1], t);
        chk("li_ready_between", 32'(req_ready), 32'd0);
        tick();
        chk("li_ready_after", 32'(req_ready), 32'd1);
        drain();

        // ---------------- LI under back-pressure for 5 cycles ----------------
        out_ready = 1'b0;
        send(tbl[1], t);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("li_stall_ready", 32'(req_ready), 32'd0);
        end
        chk("li_stall_word", out_inst, 32'h12345537);
        out_ready = 1'b1;
        drain();

        // ---------------- reset while the ADDI is pending ----------------
        out_ready = 1'b0;
        send(tbl[1], t);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        hold_chk = 1'b0;
        err_due = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_after_valid", 32'(out_valid), 32'd0);
        chk("rst_after_ready", 32'(req_ready), 32'd1);

        // ---------------- randomized against the model ----------------
        sup_ops = '{T_LOAD, T_MISC_MEM, T_OP_IMM, T_AUIPC, T_STORE, T_OP,
                    T_LUI, T_BRANCH, T_JALR, T_JAL, T_SYSTEM};
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) v.op = 5'($urandom_range(0, 31));
            else v.op = sup_ops[$urandom_range(0, 10)];
            v.li  = ($urandom_range(0, 4) == 0);
            v.f3  = 3'($urandom_range(0, 7));
            v.alt = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 31));
            v.rs1 = 5'($urandom_range(0, 31));
            v.rs2 = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: v.imm = $urandom;
                1: v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: v.imm = $urandom & 32'hFFFFF000;
                default: v.imm = 32'($urandom_range(0, 31));
            endcase
            model(v, n_m, m0, m1, e_m);
            v.n = n_m; v.w0 = m0; v.w1 = m1; v.e = e_m;
            send(v, t);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
